// File: rtl/mul_div_unit.sv
// mul_div_unit
// E-stage multiply/divide unit that owns the HI/LO registers.
//
// An accepted mult/multu/div/divu computes its 64-bit result at the issue
// edge and parks it in p_hi/p_lo. A down-counter then holds busy high for
// a fixed latency. The result is copied into HI/LO on the edge where the
// counter reaches terminal count. mthi/mtlo write HI/LO directly when the
// unit is idle. mfhi/mflo read through rd_data, which is combinational.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   req      in   flush of the E-stage instruction this cycle
//   start    in   E-stage instruction is mult/multu/div/divu
//   md_op    in   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
//   a, b     in   rs / rt operands
//   busy     out  operation in flight (cnt != 0)
//   hi, lo   out  HI / LO registers
//   rd_data  out  hi for mfhi, lo for mflo, else 0
//
// state      | meaning
// cnt == 0   | idle: accepts start / mthi / mtlo
// cnt >  1   | op in flight, counting down
// cnt == 1   | terminal count: commit p_hi/p_lo on this edge
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [CW-1:0] cnt;
  logic [31:0]   p_hi;
  logic [31:0]   p_lo;
  // Cleared for a divide by zero, so the commit leaves HI/LO untouched.
  logic          p_wr;

  logic        is_md;
  logic        is_div;
  logic        idle;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_den_s;
  logic [31:0] div_den_u;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign idle   = (cnt == '0);
  assign busy   = ~idle;
  assign is_md  = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                  (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes and then restores signs. This keeps
  // 0x80000000 / -1 well defined: the magnitude quotient 0x80000000 is
  // returned unchanged, because both operands are negative.
  assign a_neg = a[31];
  assign b_neg = b[31];
  assign mag_a = a_neg ? (~a + 32'd1) : a;
  assign mag_b = b_neg ? (~b + 32'd1) : b;

  // A zero divisor is replaced by 1 so the datapath never sees x/0. The
  // result it produces is discarded, because p_wr is cleared.
  assign div_den_s = (b == 32'd0) ? 32'd1 : mag_b;
  assign div_den_u = (b == 32'd0) ? 32'd1 : b;

  assign uq_s = mag_a / div_den_s;
  assign ur_s = mag_a % div_den_s;
  assign q_s  = (a_neg ^ b_neg) ? (~uq_s + 32'd1) : uq_s;
  assign r_s  = a_neg ? (~ur_s + 32'd1) : ur_s;
  assign q_u  = a / div_den_u;
  assign r_u  = a % div_den_u;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
      OP_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
      default:  begin res_hi = 32'd0;         res_lo = 32'd0;        end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      p_hi <= 32'd0;
      p_lo <= 32'd0;
      p_wr <= 1'b0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else if (!idle) begin
      // Anything arriving while busy is dropped. The in-flight op only counts down.
      cnt <= cnt - CW'(1);
      if ((cnt == CW'(1)) && p_wr) begin
        hi <= p_hi;
        lo <= p_lo;
      end
    end else if (!req) begin
      if (start && is_md) begin
        cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        p_hi <= res_hi;
        p_lo <= res_lo;
        p_wr <= !(is_div && (b == 32'd0));
      end else if (md_op == OP_MTHI) begin
        hi <= a;
      end else if (md_op == OP_MTLO) begin
        lo <= a;
      end
    end
  end

  always_comb begin
    rd_data = 32'd0;
    if (md_op == OP_MFHI)
      rd_data = hi;
    else if (md_op == OP_MFLO)
      rd_data = lo;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Owns the HI/LO registers.
- The E-stage controller pulses `start`; the unit raises `busy` for a fixed multi-cycle latency, then commits the result to HI/LO.
- The hazard/stall unit consumes `start` and `busy` to hold D-stage mult/div/mf/mt instructions.
- Also serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  interrupt/exception flush of the E-stage instruction this cycle
- start  in  1  E-stage instruction is mult/multu/div/divu (combinational from E decode)
- md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; others behave as none
- a  in  32  rs operand (forwarded)
- b  in  32  rt operand (forwarded)
- busy  out  1  operation in flight
- hi  out  32  HI register
- lo  out  32  LO register
- rd_data  out  32  hi if md_op=7, lo if md_op=8, else 0; combinational

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, pending result=0. Reset mid-operation aborts it with no commit.
- Internal state:
  - cnt: down-counter, at least 4 bits, wide enough for max(MULT_CYCLES, DIV_CYCLES).
  - p_hi, p_lo: pending result.
  - busy = (cnt != 0), registered-derived, no combinational path from start.
- Issue: start=1 with md_op in 1..4, req=0, cnt=0 is sampled at a rising edge. At that edge:
  - cnt <= MULT_CYCLES or DIV_CYCLES.
  - p_hi/p_lo <= result computed from a and b at that edge.
- Countdown: each edge with cnt>1 does cnt <= cnt-1. On the edge with cnt==1: cnt <= 0, hi <= p_hi, lo <= p_lo.
- Timing: busy is high for exactly N cycles after the issue edge. The new hi/lo is visible in the first cycle busy=0. start itself never asserts busy in the issue cycle; the stall unit ORs start with busy.
- Arithmetic:
  - mult: signed 32x32 to 64-bit product, {hi,lo}.
  - multu: unsigned 32x32 to 64-bit product, {hi,lo}.
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide corner cases:
  - b=0: the op still runs the full DIV_CYCLES, and hi/lo are left unchanged at commit.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo: with md_op 5/6, req=0, busy=0, hi (or lo) <= a at the edge. Single-cycle, busy stays 0.
- Ignored inputs:
  - req=1 ignores start and mthi/mtlo in that cycle; an already-issued op continues and commits.
  - start, mthi or mtlo while busy=1 is ignored (the stall unit guarantees this never happens; the unit must still not corrupt the in-flight op).
  - start with md_op outside 1..4 is ignored.
- Back-to-back ops: a new start is accepted in the first cycle busy=0, i.e. the same edge after commit is allowed. The hi/lo commit and the new issue do not conflict.
- rd_data returns hi/lo as of the current cycle, with no bypass of a pending result.

Test Plan:
- Signed multiply: reset, then start, md_op=1, a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; rd_data with md_op=8 is 0xFFFFFFFA.
- Unsigned multiply: md_op=2, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- Divide: md_op=3, a=-7 (0xFFFFFFF9), b=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. md_op=4 with the same operands gives lo=0x7FFFFFFC, hi=1. b=0 leaves prior hi/lo unchanged after 10 busy cycles.
- Flush and ignore: start with req=1 -> busy stays 0, hi/lo unchanged. mtlo a=0x1234 with busy=1 -> ignored; a later idle mtlo -> lo=0x1234 the next cycle, busy=0.
- Reset mid-operation: reset asserted on the 3rd busy cycle of a div -> busy=0, hi=lo=0 on the next cycle, and no later commit.
- Back-to-back: mult committing, then start div on the first busy=0 cycle -> hi/lo hold the mult result for 10 cycles, then the div result.
